// File: rtl/id_ex_skid_if.sv
// ID/EX handshake bundle: decode-side request/ready and EX-side valid/ready
// together with the registered control, specifier and data payloads.
interface id_ex_skid_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
);
    logic                      validD;
    logic                      readyD;
    logic [5+ALU_CTRL_W-1:0]   ctrlD;
    logic [3*REG_ADDR_W-1:0]   regsD;
    logic [3*DATA_W-1:0]       dataD;
    logic                      validE;
    logic                      readyE;
    logic [5+ALU_CTRL_W-1:0]   ctrlE;
    logic [3*REG_ADDR_W-1:0]   regsE;
    logic [3*DATA_W-1:0]       dataE;

    modport master (
        output validD, ctrlD, regsD, dataD, readyE,
        input  readyD, validE, ctrlE, regsE, dataE
    );

    modport slave (
        input  validD, ctrlD, regsD, dataD, readyE,
        output readyD, validE, ctrlE, regsE, dataE
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating EX-stall counter. readyD depends on registered state only.
module id_ex_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             statClr,
    output logic [CNT_W-1:0] stallCount,
    id_ex_skid_if.slave      bus
);
    localparam int CTRL_W     = 5 + ALU_CTRL_W;
    localparam int REG_WR_BIT = ALU_CTRL_W + 4;
    localparam int MEM_WR_BIT = ALU_CTRL_W + 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0]       ctrl;
        logic [3*REG_ADDR_W-1:0] regs;
        logic [3*DATA_W-1:0]     data;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    entry_t in_entry;
    logic   accept;
    logic   consume;
    logic   valid_e;

    assign in_entry = '{ctrl: bus.ctrlD, regs: bus.regsD, data: bus.dataD};
    assign valid_e  = (state_q != EMPTY);
    assign accept   = bus.validD & bus.readyD;
    assign consume  = valid_e & bus.readyE;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        main_d = in_entry;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (statClr) begin
            stall_d = '0;
        end else if (valid_e && !bus.readyE && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // NOTE: the payload entries are reset too, because E outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        bus.ctrlE = main_q.ctrl;
        if (!valid_e) begin
            bus.ctrlE[REG_WR_BIT] = 1'b0;
            bus.ctrlE[MEM_WR_BIT] = 1'b0;
        end
    end

    assign bus.readyD = (state_q != SKID);
    assign bus.validE = valid_e;
    assign bus.regsE  = main_q.regs;
    assign bus.dataE  = main_q.data;
    assign stallCount = stall_q;
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomized self-checking bench for id_ex_skid_reg, compared against a
// queue-based model of the ID/EX register contents.
module tb_id_ex_skid_reg;
    localparam int DATA_W = 32, REG_ADDR_W = 5, ALU_CTRL_W = 4, CNT_W = 4;
    localparam int CTRL_W = 5 + ALU_CTRL_W;
    localparam int REG_WR = CTRL_W - 1;
    localparam int MEM_WR = CTRL_W - 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [CTRL_W-1:0]       ctrl;
        logic [3*REG_ADDR_W-1:0] regs;
        logic [3*DATA_W-1:0]     data;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             statClr;
    logic [CNT_W-1:0] stallCount;

    int checks = 0;
    int errors = 0;

    id_ex_skid_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALU_CTRL_W(ALU_CTRL_W)) bus ();

    id_ex_skid_reg #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALU_CTRL_W(ALU_CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .statClr(statClr),
        .stallCount(stallCount), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: the in-flight instructions in FIFO order, the last
    // instruction shown on the E side, and the stall counter.
    entry_t           mq[$];
    entry_t           last_shown;
    logic [CNT_W-1:0] m_cnt;

    function automatic entry_t rand_entry();
        entry_t e;
        e.ctrl = CTRL_W'($urandom);
        e.regs = (3*REG_ADDR_W)'($urandom);
        e.data = {$urandom, $urandom, $urandom};
        return e;
    endfunction

    function automatic logic [CTRL_W-1:0] exp_ctrl();
        logic [CTRL_W-1:0] c;
        c = last_shown.ctrl;
        if (mq.size() == 0) begin
            c[REG_WR] = 1'b0;
            c[MEM_WR] = 1'b0;
        end
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        last_shown = '0;
        m_cnt = '0;
    endtask

    // Applies one cycle of stimulus, advances the model, and returns 1 time unit after the edge.
    task automatic cycle(input logic vd, input logic re, input logic fl, input logic clr, input entry_t e);
        logic acc, con;
        bus.validD = vd;
        bus.readyE = re;
        flush      = fl;
        statClr    = clr;
        {bus.ctrlD, bus.regsD, bus.dataD} = e;
        acc = vd && (mq.size() < 2);
        con = re && (mq.size() > 0);
        if (clr) m_cnt = '0;
        else if (mq.size() > 0 && !re && !fl && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        if (fl) mq.delete();
        else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        if (mq.size() > 0) last_shown = mq[0];
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
    endtask

    task automatic test_reset();
        entry_t e;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            bus.validD = 1'b1;
            bus.readyE = i[0];
            flush = 1'b0;
            statClr = 1'b0;
            {bus.ctrlD, bus.regsD, bus.dataD} = rand_entry();
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.validE !== 1'b0 || bus.readyD !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: validE=%b readyD=%b, required 0/1", bus.validE, bus.readyD);
        end
        checks++;
        if (bus.ctrlE !== '0 || bus.regsE !== '0 || bus.dataE !== '0 || stallCount !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ctrlE=%h regsE=%h dataE=%h stall=%0d, required all 0",
                     bus.ctrlE, bus.regsE, bus.dataE, stallCount);
        end
        #2 rst_n = 1'b1;
        e = rand_entry();
        e.data = {32'd1, 32'd2, 32'd3};
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        checks++;
        if (bus.validE !== 1'b1 || bus.dataE !== {32'd1, 32'd2, 32'd3}) begin
            errors++;
            $display("FAIL reset_first_accept: validE=%b dataE=%h, required 1/%h",
                     bus.validE, bus.dataE, {32'd1, 32'd2, 32'd3});
        end
        drain();
    endtask

    task automatic test_streaming();
        entry_t e;
        for (int i = 0; i < 8; i++) begin
            e = rand_entry();
            e.data[3*DATA_W-1 -: DATA_W] = i;
            cycle(1'b1, 1'b1, 1'b0, 1'b0, e);
            checks++;
            if (bus.validE !== 1'b1 || bus.readyD !== 1'b1 ||
                bus.dataE[3*DATA_W-1 -: DATA_W] !== 32'(i)) begin
                errors++;
                $display("FAIL stream_%0d: validE=%b readyD=%b data1=%0d, required 1/1/%0d",
                         i, bus.validE, bus.readyD, bus.dataE[3*DATA_W-1 -: DATA_W], i);
            end
        end
        drain();
    endtask

    task automatic test_skid();
        entry_t a, b;
        a = rand_entry();
        b = rand_entry();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, rand_entry());
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        checks++;
        if (bus.readyD !== 1'b0 || bus.validE !== 1'b1 || bus.dataE !== a.data || bus.ctrlE !== a.ctrl) begin
            errors++;
            $display("FAIL skid_full: readyD=%b validE=%b dataE=%h, required 0/1/%h",
                     bus.readyD, bus.validE, bus.dataE, a.data);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
        checks++;
        if (bus.validE !== 1'b1 || bus.dataE !== b.data || bus.regsE !== b.regs || bus.readyD !== 1'b1) begin
            errors++;
            $display("FAIL skid_second: validE=%b dataE=%h readyD=%b, required 1/%h/1",
                     bus.validE, bus.dataE, bus.readyD, b.data);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
        checks++;
        if (bus.validE !== 1'b0 || stallCount !== 4'd1) begin
            errors++;
            $display("FAIL skid_drained: validE=%b stall=%0d, required 0/1", bus.validE, stallCount);
        end
    endtask

    task automatic test_flush();
        entry_t a, b, c;
        a = rand_entry();
        b = rand_entry();
        c = rand_entry();
        a.ctrl[REG_WR] = 1'b1;
        a.ctrl[MEM_WR] = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, c);
        checks++;
        if (bus.validE !== 1'b0 || bus.readyD !== 1'b1 || bus.ctrlE !== exp_ctrl()) begin
            errors++;
            $display("FAIL flush_bubble: validE=%b readyD=%b ctrlE=%h, required 0/1/%h",
                     bus.validE, bus.readyD, bus.ctrlE, exp_ctrl());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
            checks++;
            if (bus.validE !== 1'b0 || bus.dataE !== a.data) begin
                errors++;
                $display("FAIL flush_no_leak_%0d: validE=%b dataE=%h, required 0/%h",
                         i, bus.validE, bus.dataE, a.data);
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_entry());
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rand_entry());
        checks++;
        if (stallCount !== CNT_MAX) begin
            errors++;
            $display("FAIL sat_max: stall=%0d, required %0d", stallCount, CNT_MAX);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, rand_entry());
        checks++;
        if (stallCount !== '0) begin
            errors++;
            $display("FAIL sat_clear: stall=%0d, required 0", stallCount);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rand_entry());
        checks++;
        if (stallCount !== 4'd1) begin
            errors++;
            $display("FAIL sat_resume: stall=%0d, required 1", stallCount);
        end
        drain();
    endtask

    task automatic test_async_reset();
        entry_t e;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_entry());
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_entry());
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rand_entry());
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.validE !== 1'b0 || bus.readyD !== 1'b1 || bus.dataE !== '0 ||
            bus.ctrlE !== '0 || bus.regsE !== '0 || stallCount !== '0) begin
            errors++;
            $display("FAIL async_reset: validE=%b readyD=%b dataE=%h stall=%0d, required 0/1/0/0",
                     bus.validE, bus.readyD, bus.dataE, stallCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
        checks++;
        if (bus.validE !== 1'b0) begin
            errors++;
            $display("FAIL async_discard: validE=%b, required 0", bus.validE);
        end
        e = rand_entry();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        checks++;
        if (bus.validE !== 1'b1 || bus.dataE !== e.data) begin
            errors++;
            $display("FAIL async_restart: validE=%b dataE=%h, required 1/%h", bus.validE, bus.dataE, e.data);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0), rand_entry());
            checks++;
            if (bus.validE !== (mq.size() != 0) || bus.readyD !== (mq.size() < 2) ||
                bus.ctrlE !== exp_ctrl() || bus.regsE !== last_shown.regs ||
                bus.dataE !== last_shown.data || stallCount !== m_cnt) begin
                errors++;
                $display("FAIL random_%0d: validE=%b readyD=%b ctrlE=%h dataE=%h stall=%0d, required %b/%b/%h/%h/%0d",
                         i, bus.validE, bus.readyD, bus.ctrlE, bus.dataE, stallCount,
                         mq.size() != 0, mq.size() < 2, exp_ctrl(), last_shown.data, m_cnt);
            end
        end
    endtask

    initial begin
        bus.validD = 1'b0;
        bus.readyE = 1'b0;
        bus.ctrlD = '0;
        bus.regsD = '0;
        bus.dataD = '0;
        flush = 1'b0;
        statClr = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
